// File: rtl/sa_col_drain.sv
// Column drain for the systolic array: captures one row of COL accumulators and
// serializes them one column per cycle. Optional macro DRAIN_BIAS_EN adds a saturating per-row bias.
module sa_col_drain #(
  parameter int COL   = 3,
  parameter int W_ACC = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [COL*W_ACC-1:0]   i_psum,
`ifdef DRAIN_BIAS_EN
  input  logic [W_ACC-1:0]       i_bias,
`endif
  input  logic                   i_hold,
  output logic [W_ACC-1:0]       o_data,
  output logic [COL-1:0]         o_data_valid,
  output logic                   o_last,
  output logic                   o_busy
);

  localparam int IW = (COL > 1) ? $clog2(COL) : 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [W_ACC-1:0] shadow [COL];
  logic [W_ACC-1:0] word_out;
  logic             last_col;
  logic             load_accept;

  assign last_col = (idx == IW'(COL - 1));

  // Ready also on the final column so the next row follows without a bubble.
  assign o_load_ready = !rst && ((state == IDLE) ||
                                 ((state == DRAIN) && last_col && !i_hold));
  assign load_accept  = i_load_valid && o_load_ready;

`ifdef DRAIN_BIAS_EN
  logic [W_ACC-1:0] bias_q;
  logic [W_ACC:0]   sum_ext;

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
  always_comb begin
    sum_ext  = {shadow[idx][W_ACC-1], shadow[idx]} + {bias_q[W_ACC-1], bias_q};
    word_out = sum_ext[W_ACC-1:0];
    if (sum_ext[W_ACC] != sum_ext[W_ACC-1]) begin
      word_out = sum_ext[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}}
                                : {1'b0, {(W_ACC-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
    end else if (load_accept) begin
      bias_q <= i_bias;
    end
  end
`else
  always_comb begin
    word_out = shadow[idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      o_data       <= '0;
      o_data_valid <= '0;
      o_last       <= 1'b0;
      o_busy       <= 1'b0;
      for (int c = 0; c < COL; c++) begin
        shadow[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          o_data_valid <= '0;
          o_last       <= 1'b0;
          if (load_accept) begin
            for (int c = 0; c < COL; c++) begin
              shadow[c] <= i_psum[c*W_ACC +: W_ACC];
            end
            idx    <= '0;
            state  <= DRAIN;
            o_busy <= 1'b1;
          end
        end

        DRAIN: begin
          if (i_hold) begin
            // Stall: data and position stay put so no column is lost or repeated.
            o_data_valid <= '0;
            o_last       <= 1'b0;
          end else begin
            o_data       <= word_out;
            o_data_valid <= COL'(1) << idx;
            o_last       <= last_col;
            if (!last_col) begin
              idx <= idx + IW'(1);
            end else if (load_accept) begin
              for (int c = 0; c < COL; c++) begin
                shadow[c] <= i_psum[c*W_ACC +: W_ACC];
              end
              idx <= '0;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
